// File: rtl/mult_pkg.sv
// Shared types for the iterative shift-add multiplier.
// The controller only needs its state encoding here; operand-width types live with WIDTH.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/mult_step.sv
// One shift-add step of the multiplier: conditional add (or final subtract in signed mode),
// then a one-bit right shift of {A,B}. Purely combinational so it can be replicated when unrolled.
module mult_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_m,
  input  logic             i_s,
  input  logic             i_last,
  output logic             o_x,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  typedef struct packed {
    logic             x;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } step_t;

  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_m_ext;
  logic [WIDTH:0] w_sum;
  step_t          w_step;

  always_comb begin
    w_a_ext = {i_s & i_a[WIDTH-1], i_a};
    w_m_ext = {i_s & i_m[WIDTH-1], i_m};
    // The multiplier's MSB carries negative weight in two's complement, so its partial product is subtracted.
    if (i_s && i_last && i_b[0]) begin
      w_sum = w_a_ext - w_m_ext;
    end else if (i_b[0]) begin
      w_sum = w_a_ext + w_m_ext;
    end else begin
      w_sum = w_a_ext;
    end
  end

  // The (W+1)-bit sum cannot overflow, so its top bit is the true sign / carry shifted into A.
  always_comb begin
    w_step.x = i_s & w_sum[WIDTH];
    w_step.a = w_sum[WIDTH:1];
    w_step.b = {w_sum[0], i_b[WIDTH-1:1]};
  end

  assign o_x = w_step.x;
  assign o_a = w_step.a;
  assign o_b = w_step.b;

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative W x W multiplier, one product bit per clock; signed or unsigned, result in {A,B}.
// state   | meaning
// IDLE    | waiting; Load writes B, a Run rising edge latches M/S and starts
// COMPUTE | one add/shift step per clock, W steps
// DONE    | product valid, Done pulses for this cycle
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_signed_mode,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_x,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic             r_x;
  logic             r_s;
  logic             r_run_q;
  logic [CNT_W-1:0] r_cnt;

  logic             w_start;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic             w_step_x;
  logic [WIDTH-1:0] w_step_a;
  logic [WIDTH-1:0] w_step_b;

  assign w_last = (r_cnt == LAST_CNT);

  mult_step #(.WIDTH(WIDTH)) u_step (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_m    (r_m),
    .i_s    (r_s),
    .i_last (w_last),
    .o_x    (w_step_x),
    .o_a    (w_step_a),
    .o_b    (w_step_b)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        // Load wins over a coincident Run edge; run_q still advances, so that edge is lost.
        if (!i_load && i_run && !r_run_q) begin
          w_start     = 1'b1;
          w_state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= 1'b0;
      r_m     <= '0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
      r_run_q <= 1'b0;
    end else begin
      r_run_q <= i_run;
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_b <= i_din;
            r_a <= '0;
            r_x <= 1'b0;
          end else if (w_start) begin
            r_a   <= '0;
            r_x   <= 1'b0;
            r_m   <= i_din;
            r_s   <= i_signed_mode;
            r_cnt <= '0;
          end
        end
        COMPUTE: begin
          r_a   <= w_step_a;
          r_b   <= w_step_b;
          r_x   <= w_step_x;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_a    = r_a;
  assign o_b    = r_b;
  assign o_x    = r_x;
  assign o_busy = w_busy;
  assign o_done = w_done;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at WIDTH=8 and WIDTH=16.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;

  logic        load8, run8, sm8;
  logic [7:0]  din8, a8, b8;
  logic        x8, busy8, done8;

  logic        load16, run16, sm16;
  logic [15:0] din16, a16, b16;
  logic        x16, busy16, done16;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_load        (load8),
    .i_run         (run8),
    .i_signed_mode (sm8),
    .i_din         (din8),
    .o_a           (a8),
    .o_b           (b8),
    .o_x           (x8),
    .o_busy        (busy8),
    .o_done        (done8)
  );

  shift_add_multiplier #(.WIDTH(16)) dut16 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_load        (load16),
    .i_run         (run16),
    .i_signed_mode (sm16),
    .i_din         (din16),
    .o_a           (a16),
    .o_b           (b16),
    .o_x           (x16),
    .o_busy        (busy16),
    .o_done        (done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load8(input logic [7:0] din);
    @(negedge clk);
    load8 = 1'b1;
    din8  = din;
    @(negedge clk);
    load8 = 1'b0;
  endtask

  // Called at the negedge of a cycle with index k0 after the start edge.
  task automatic wait_done8(input int k0, output int busy_cycles, output int done_at);
    busy_cycles = 0;
    done_at     = -1;
    for (int k = k0; k <= k0 + 40; k++) begin
      if (busy8) busy_cycles++;
      if (done8) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run8_mult(input logic [7:0] din, input logic sm, output int busy_cycles, output int done_at);
    @(negedge clk);
    din8 = din;
    sm8  = sm;
    run8 = 1'b1;
    @(negedge clk);
    run8 = 1'b0;
    wait_done8(1, busy_cycles, done_at);
  endtask

  initial begin
    int bc, da;
    rst_n = 1'b0;
    load8 = 0; run8 = 0; sm8 = 0; din8 = '0;
    load16 = 0; run16 = 0; sm16 = 0; din16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_a", a8, 8'h00);
    chk("rst_b", b8, 8'h00);
    chk("rst_busy_done", {busy8, done8, x8}, 3'b000);
    rst_n = 1'b1;

    // -2 * 3 = -6
    do_load8(8'hFE);
    chk("load_b", b8, 8'hFE);
    run8_mult(8'h03, 1'b1, bc, da);
    chk("s_m6_done_at", da, 9);
    chk("s_m6_busy", bc, 8);
    chk("s_m6_ab", {a8, b8}, 16'hFFFA);
    chk("s_m6_x", x8, 1'b1);
    @(negedge clk);
    chk("done_pulse_once", done8, 1'b0);
    chk("s_m6_hold", {x8, a8, b8}, 17'h1FFFA);

    // 255 * 255 unsigned, then -1 * -1 signed
    do_load8(8'hFF);
    run8_mult(8'hFF, 1'b0, bc, da);
    chk("u_ff_ab", {a8, b8}, 16'hFE01);
    chk("u_ff_x", x8, 1'b0);
    do_load8(8'hFF);
    run8_mult(8'hFF, 1'b1, bc, da);
    chk("s_m1_ab", {x8, a8, b8}, 17'h00001);

    // (-128)^2, then back-to-back 0x00 * 2
    do_load8(8'h80);
    run8_mult(8'h80, 1'b1, bc, da);
    chk("s_m128_ab", {x8, a8, b8}, 17'h04000);
    run8_mult(8'h02, 1'b1, bc, da);
    chk("b2b_ab", {x8, a8, b8}, 17'h00000);
    chk("b2b_done_at", da, 9);

    // asynchronous reset in the 4th COMPUTE cycle
    do_load8(8'h05);
    @(negedge clk);
    din8 = 8'h07; sm8 = 1'b0; run8 = 1'b1;
    @(negedge clk);
    run8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_abx", {x8, a8, b8}, 17'h00000);
    chk("mid_rst_busy", {busy8, done8}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", busy8, 1'b0);
    do_load8(8'h06);
    run8_mult(8'h07, 1'b0, bc, da);
    chk("post_rst_ab", {a8, b8}, 16'h002A);
    chk("post_rst_done_at", da, 9);

    // Load/Run toggled during COMPUTE: 13 * 11 = 143
    do_load8(8'h0D);
    @(negedge clk);
    din8 = 8'h0B; sm8 = 1'b0; run8 = 1'b1;
    @(negedge clk);
    run8 = 1'b0; din8 = 8'hFF; sm8 = 1'b1;
    @(negedge clk);
    load8 = 1'b1; run8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0; run8 = 1'b0;
    @(negedge clk);
    load8 = 1'b1; run8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0; run8 = 1'b0;
    wait_done8(5, bc, da);
    chk("toggle_done_at", da, 9);
    chk("toggle_ab", {x8, a8, b8}, 17'h0008F);

    // Load and Run rising together in IDLE
    @(negedge clk);
    load8 = 1'b1; run8 = 1'b1; din8 = 8'h33;
    @(negedge clk);
    chk("ld_run_b", b8, 8'h33);
    chk("ld_run_busy", busy8, 1'b0);
    load8 = 1'b0;
    @(negedge clk);
    chk("ld_run_edge_lost", busy8, 1'b0);
    run8 = 1'b0;
    @(negedge clk);
    chk("ld_run_still_idle", {busy8, b8}, 9'h033);

    // WIDTH=16: 0x8001 * -1 = 0x00007FFF
    @(negedge clk);
    load16 = 1'b1; din16 = 16'h8001;
    @(negedge clk);
    load16 = 1'b0; din16 = 16'hFFFF; sm16 = 1'b1; run16 = 1'b1;
    @(negedge clk);
    run16 = 1'b0;
    bc = 0;
    da = -1;
    for (int k = 1; k <= 60; k++) begin
      if (busy16) bc++;
      if (done16) begin
        da = k;
        break;
      end
      @(negedge clk);
    end
    chk("w16_done_at", da, 17);
    chk("w16_busy", bc, 16);
    chk("w16_ab", {a16, b16}, 32'h00007FFF);
    chk("w16_x", x16, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
